// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache core port among PORT_COUNT masters, one transaction in flight.
// Latency: 1 cycle req->s_req_o, then gnt/rvalid pass through combinationally; others wait while busy.
module cache_port_arbiter #(
   parameter int PORT_COUNT = 2,
   localparam int OW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PORT_COUNT-1:0]    m_req_i,
   input  logic [PORT_COUNT*32-1:0] m_addr_i,
   input  logic [PORT_COUNT*32-1:0] m_wdata_i,
   input  logic [PORT_COUNT-1:0]    m_we_i,
   input  logic [PORT_COUNT*4-1:0]  m_be_i,
   output logic [PORT_COUNT-1:0]    m_gnt_o,
   output logic [PORT_COUNT-1:0]    m_rvalid_o,
   output logic [31:0]              m_rdata_o,
   output logic [PORT_COUNT-1:0]    m_error_o,
   output logic                     s_req_o,
   output logic [31:0]              s_addr_o,
   output logic [31:0]              s_wdata_o,
   output logic                     s_we_o,
   output logic [3:0]               s_be_o,
   input  logic                     s_gnt_i,
   input  logic                     s_rvalid_i,
   input  logic                     s_error_i,
   input  logic [31:0]              s_rdata_i,
   output logic [OW-1:0]            owner_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

   state_t        state_q;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic          owner_req;
   logic          gnt_fire;
   logic          rsp_fire;
   logic [31:0]   sel_addr, sel_wdata;
   logic          sel_we;
   logic [3:0]    sel_be;

   // First requester at or after rr_ptr, wrapping modulo PORT_COUNT.
   always_comb begin
      logic [OW:0] idx;
      logic        found;
      owner_d = rr_ptr_q;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         idx = {1'b0, rr_ptr_q} + (OW+1)'(i);
         if (idx >= (OW+1)'(PORT_COUNT)) begin
            idx = idx - (OW+1)'(PORT_COUNT);
         end
         if (!found && m_req_i[idx[OW-1:0]]) begin
            owner_d = idx[OW-1:0];
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      sel_be    = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         if (owner_q == OW'(p)) begin
            sel_addr  = m_addr_i[32*p +: 32];
            sel_wdata = m_wdata_i[32*p +: 32];
            sel_we    = m_we_i[p];
            sel_be    = m_be_i[4*p +: 4];
         end
      end
   end

   assign owner_req = m_req_i[owner_q];
   assign rr_ptr_d  = (owner_q == OW'(PORT_COUNT-1)) ? '0 : owner_q + OW'(1);
   // Handshakes are gated by reset so a response arriving during reset is dropped.
   assign gnt_fire  = !reset && (state_q == ST_REQ) && owner_req && s_gnt_i;
   assign rsp_fire  = !reset && s_rvalid_i && ((state_q == ST_WAIT) || gnt_fire);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|m_req_i) begin
                  owner_q <= owner_d;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!owner_req) begin
                  state_q <= ST_IDLE;
               end else if (s_gnt_i) begin
                  if (s_rvalid_i) begin
                     rr_ptr_q <= rr_ptr_d;
                     state_q  <= ST_IDLE;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (s_rvalid_i) begin
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_error_o  = '0;
      if (gnt_fire) begin
         m_gnt_o[owner_q] = 1'b1;
      end
      if (rsp_fire) begin
         m_rvalid_o[owner_q] = 1'b1;
         m_error_o[owner_q]  = s_error_i;
      end
   end

   assign m_rdata_o = rsp_fire ? s_rdata_i : '0;
   assign s_req_o   = !reset && (state_q == ST_REQ) && owner_req;
   assign s_addr_o  = (state_q != ST_IDLE) ? sel_addr  : '0;
   assign s_wdata_o = (state_q != ST_IDLE) ? sel_wdata : '0;
   assign s_we_o    = (state_q != ST_IDLE) ? sel_we    : 1'b0;
   assign s_be_o    = (state_q != ST_IDLE) ? sel_be    : '0;
   assign owner_o   = owner_q;
   assign busy_o    = (state_q != ST_IDLE);

endmodule
